// File: rtl/msk_pkg.sv
// Shared definitions for the masked-datapath blocks: sharing index helper,
// constant clog2 and the rate-buffer state encoding.
package msk_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Position of share j of unmasked bit b in a d-share bus.
  function automatic int share_idx(input int b, input int j, input int d);
    return b * d + j;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/msk_reg_en.sv
// Masked lane register: one flop per share bit, synchronous clear beats enable.
module msk_reg_en #(
  parameter int d     = 2,
  parameter int count = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [count*d-1:0]   din,
  output logic [count*d-1:0]   q
);

  // Keep attributes stop synthesis from merging or retiming individual shares.
  (* keep = "true", syn_keep = "true" *) logic [count*d-1:0] q_r;

  always_ff @(posedge clk) begin
    if (rst || clr) q_r <= '0;
    else if (en)    q_r <= din;
  end

  assign q = q_r;

endmodule

// File: rtl/msk_rate_buffer.sv
// Collects NW masked words into one held rate block for the masked state mux.
//   state | meaning
//   FILL  | accepting words into lane cnt, block not presented
//   FULL  | block held on out_data, waiting for out_ready
module msk_rate_buffer
  import msk_pkg::*;
#(
  parameter int d  = 2,
  parameter int W  = 32,
  parameter int NW = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W*d-1:0]            in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NW*W*d-1:0]         out_data,
  output logic                      out_last,
  output logic [clog2(NW+1)-1:0]    out_nwords
);

  localparam int CNT_W = (NW > 1) ? clog2(NW) : 1;
  localparam int NWD_W = clog2(NW + 1);
  localparam int LW    = W * d;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_word;

  assign accept    = (state == FILL) && in_valid;
  assign last_word = in_last || (cnt == CNT_W'(NW - 1));

  // Lane selection depends only on cnt, never on share contents.
  for (genvar k = 0; k < NW; k++) begin : g_lane
    logic lane_en, lane_clr;
    assign lane_en  = accept && (cnt == CNT_W'(k));
    assign lane_clr = accept && last_word && (CNT_W'(k) > cnt);

    msk_reg_en #(.d(d), .count(W)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (lane_en),
      .clr (lane_clr),
      .din (in_data),
      .q   (out_data[(NW-k)*LW-1 -: LW])
    );
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && last_word) state_nxt = FULL;
      end
      FULL: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      cnt        <= '0;
      out_last   <= 1'b0;
      out_nwords <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (last_word) begin
          cnt        <= '0;
          out_nwords <= NWD_W'(cnt) + NWD_W'(1);
          out_last   <= in_last;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if ((state == FULL) && out_ready) begin
        // Block data stays on the bus; only the descriptors are dropped.
        out_last   <= 1'b0;
        out_nwords <= '0;
      end
    end
  end

endmodule
